load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles to wait for mem_ack per memory access; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-low (rst=0 resets on posedge clk).
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit can accept an access.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  load result, extended to 32 bits.
REQ-012 SHALL have port resp_err  output  1  misaligned, illegal or timed-out access.
REQ-013 SHALL have port mem_req  output  1  word access request to data memory.
REQ-014 SHALL have port mem_we  output  1  1=word write, 0=word read.
REQ-015 SHALL have port mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 SHALL have port mem_wdata  output  32  full little-endian word to write.
REQ-017 SHALL have port mem_rdata  input  32  little-endian word read, valid when mem_ack=1.
REQ-018 SHALL have port mem_ack  input  1  memory completes the current access this cycle; may be high in the same cycle as mem_req.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL latch req_we, req_funct3, req_addr and req_wdata on a cycle where req_valid=1 and req_ready=1; later changes on the inputs have no effect.
REQ-021 SHALL flag an error for: funct3 in {3,6,7}; store with funct3>2; H/HU/SH with addr[0]=1; W with addr[1:0]!=0.
REQ-022 SHALL go IDLE->RESP on an error access, with no mem_req.
REQ-023 SHALL go IDLE->RD for legal loads and SB/SH, and IDLE->WR for legal SW.
REQ-024 SHALL drive mem_req=1, mem_we=0 in RD; on mem_ack, capture mem_rdata and go to RESP (load) or WR (SB/SH).
REQ-025 SHALL drive mem_req=1, mem_we=1 in WR with mem_wdata = the captured word with only the addressed lane(s) replaced (SB: byte addr[1:0]; SH: half addr[1]; SW: req_wdata); on mem_ack go to RESP.
REQ-026 SHALL drive mem_req=0 in IDLE and RESP; mem_addr and mem_wdata SHALL hold stable while mem_req=1.
REQ-027 SHALL count cycles in RD/WR without mem_ack; when TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, go to RESP with resp_err=1 and skip any pending WR; the count clears on every state entry.
REQ-028 SHALL assert resp_valid=1 for exactly one cycle in RESP, then return to IDLE; a new request is accepted no earlier than the next cycle.
REQ-029 SHALL produce resp_rdata as follows: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW returns the whole word; stores and errors return 0.
REQ-030 SHALL give, with zero-wait memory (mem_ack=1 whenever mem_req=1), resp_valid at 2 cycles after acceptance for loads and SW, 3 for SB/SH and 1 for errors; each wait cycle adds 1.

Reset
REQ-031 SHALL, on rst=0 at posedge, go to IDLE, clear the timeout count and drive req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL abandon an in-flight access when reset is applied mid-operation: no resp_valid and no further mem_req until a new request is accepted.

Verification
REQ-033 SHALL pass this case: memory word 0x10 = 0x8899AABB, LB addr 0x11 -> mem read 0x10, resp_rdata 0xFFFFFFAA, resp_err 0, 2 cycles.
REQ-034 SHALL pass this case: memory word 0x10 = 0x8899AABB, LHU addr 0x12 -> resp_rdata 0x00008899.
REQ-035 SHALL pass this case: memory word 0x20 = 0x11223344, SB addr 0x23, wdata 0x000000EE -> read 0x20, then write 0xEE223344 to 0x20, resp_valid at 3 cycles.
REQ-036 SHALL pass this case: LW addr 0x06 -> no mem_req, resp_err 1, resp_rdata 0, resp_valid 1 cycle after acceptance.
REQ-037 SHALL pass this case: TIMEOUT_CYCLES=4, mem_ack held 0 on LW 0x40 -> resp_err 1 after 4 cycles in RD, mem_req drops, req_ready returns.
REQ-038 SHALL pass this case: rst=0 during WR of an SH -> next cycle IDLE, mem_req 0, no resp_valid, then a following LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; master is the core/memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr,
        mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr,
        mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide data memory. Sub-word stores are done as
// read-modify-write; every memory access is bounded by an optional ack timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              access_err, timeout_hit;
    logic [31:0]       rd_shift, load_val, merged;

    always_comb begin
        access_err = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5)
                  || (bus.req_we && (bus.req_funct3 > 3'd2))
                  || (((bus.req_funct3 == 3'd1) || (bus.req_funct3 == 3'd5)) && bus.req_addr[0])
                  || ((bus.req_funct3 == 3'd2) && (bus.req_addr[1:0] != 2'b00));

        rd_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {24'd0, rd_shift[7:0]};
            3'd5:    load_val = {16'd0, rd_shift[15:0]};
            default: load_val = bus.mem_rdata;
        endcase

        // Only the addressed lane(s) of the previously read word are replaced.
        merged = word_q;
        case (funct3_q[1:0])
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase

        cnt_inc     = cnt_q + CntW'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = access_err;
                    if (access_err) begin
                        state_d = StResp;
                    end else if (bus.req_we && (bus.req_funct3 == 3'd2)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (bus.mem_ack) begin
                    cnt_d  = '0;
                    word_d = bus.mem_rdata;
                    if (we_q) begin
                        state_d = StWr;
                    end else begin
                        rdata_d = load_val;
                        state_d = StResp;
                    end
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWr: begin
                if (bus.mem_ack) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = (state_q == StResp) ? rdata_q : 32'd0;
    assign bus.resp_err   = (state_q == StResp) && err_q;
    assign bus.mem_req    = (state_q == StRd) || (state_q == StWr);
    assign bus.mem_we     = (state_q == StWr);
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = merged;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses and memory handshakes are
// queued at issue time and checked by independent monitors.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mop_t;

    exp_t exp_q[$];
    mop_t mop_q[$];
    int   acc_q[$];
    exp_t e_mon;
    mop_t m_mon;
    int   a_mon;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 32 words, configurable wait states, ack may be disabled entirely.
    logic [31:0] mem [0:31];
    int          wait_cnt;
    int          wait_target = 0;
    logic        ack_en = 1'b1;

    assign bus.mem_rdata = mem[bus.mem_addr[6:2]];
    assign bus.mem_ack   = bus.mem_req && ack_en && (wait_cnt >= wait_target);

    always @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[4]  <= 32'h8899AABB;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'hCAFEF00D;
        end else begin
            if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
            else                             wait_cnt <= 0;
            if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.resp_valid) begin
            check("resp expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                a_mon = (acc_q.size() != 0) ? acc_q.pop_front() : 0;
                check("resp_rdata", bus.resp_rdata, e_mon.rdata);
                check("resp_err", 32'(bus.resp_err), 32'(e_mon.err));
                check("latency", 32'(cyc + 1 - a_mon), 32'(e_mon.lat));
            end
        end
        if (rst && bus.mem_req && bus.mem_ack) begin
            check("mem op expected", 32'(mop_q.size() != 0), 32'd1);
            if (mop_q.size() != 0) begin
                m_mon = mop_q.pop_front();
                check("mem_we", 32'(bus.mem_we), 32'(m_mon.we));
                check("mem_addr", bus.mem_addr, m_mon.addr);
                if (m_mon.we) check("mem_wdata", bus.mem_wdata, m_mon.data);
            end
        end
    end

    task automatic push_mop(input logic we, input logic [31:0] addr, input logic [31:0] data);
        mop_t m;
        m.we = we; m.addr = addr; m.data = data;
        mop_q.push_back(m);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
        exp_t e;
        int   n;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = lat;
        exp_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the unit must use its latched copy.
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("resp arrived", 32'(exp_q.size()), 32'd0);
        check("mem ops done", 32'(mop_q.size()), 32'd0);
        exp_q.delete();
        acc_q.delete();
        mop_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Loads, zero-wait memory
        push_mop(0, 32'h10, 0); issue(0, 3'd0, 32'h11, 0, 32'hFFFFFFAA, 0, 2);
        push_mop(0, 32'h10, 0); issue(0, 3'd5, 32'h12, 0, 32'h00008899, 0, 2);
        push_mop(0, 32'h10, 0); issue(0, 3'd1, 32'h12, 0, 32'hFFFF8899, 0, 2);
        push_mop(0, 32'h10, 0); issue(0, 3'd4, 32'h13, 0, 32'h00000088, 0, 2);
        push_mop(0, 32'h10, 0); issue(0, 3'd2, 32'h10, 0, 32'h8899AABB, 0, 2);
        // Stores: SB/SH read-modify-write, SW direct
        push_mop(0, 32'h20, 0); push_mop(1, 32'h20, 32'hEE223344);
        issue(1, 3'd0, 32'h23, 32'h000000EE, 32'd0, 0, 3);
        push_mop(0, 32'h20, 0); issue(0, 3'd2, 32'h20, 0, 32'hEE223344, 0, 2);
        push_mop(0, 32'h30, 0); push_mop(1, 32'h30, 32'h5678F00D);
        issue(1, 3'd1, 32'h32, 32'h12345678, 32'd0, 0, 3);
        push_mop(1, 32'h34, 32'hDEADBEEF); issue(1, 3'd2, 32'h34, 32'hDEADBEEF, 32'd0, 0, 2);
        push_mop(0, 32'h34, 0); issue(0, 3'd2, 32'h34, 0, 32'hDEADBEEF, 0, 2);
        // Illegal / misaligned accesses: no memory traffic, 1-cycle error response
        issue(0, 3'd2, 32'h06, 0, 32'd0, 1, 1);
        issue(0, 3'd3, 32'h10, 0, 32'd0, 1, 1);
        issue(1, 3'd4, 32'h10, 32'h55, 32'd0, 1, 1);
        issue(0, 3'd1, 32'h11, 0, 32'd0, 1, 1);
        issue(0, 3'd7, 32'h10, 0, 32'd0, 1, 1);
        // Two wait states on a load
        wait_target = 2;
        push_mop(0, 32'h30, 0); issue(0, 3'd1, 32'h30, 0, 32'hFFFFF00D, 0, 4);
        wait_target = 0;
        // Timeout: no ack at all
        ack_en = 1'b0;
        issue(0, 3'd2, 32'h40, 0, 32'd0, 1, 5);
        ack_en = 1'b1;
        check("post-timeout mem_req", 32'(bus.mem_req), 32'd0);
        check("post-timeout req_ready", 32'(bus.req_ready), 32'd1);

        // Reset during the write phase of an SH
        push_mop(0, 32'h20, 0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'h22;
        bus.req_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 ack_en = 1'b0;
        @(negedge clk);
        check("WR mem_req", 32'(bus.mem_req), 32'd1);
        check("WR mem_we", 32'(bus.mem_we), 32'd1);
        check("WR mem_addr", bus.mem_addr, 32'h20);
        check("WR mem_wdata", bus.mem_wdata, 32'hBEEF3344);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after rst mem_req", 32'(bus.mem_req), 32'd0);
            check("after rst resp_valid", 32'(bus.resp_valid), 32'd0);
            check("after rst req_ready", 32'(bus.req_ready), 32'd1);
        end
        check("after rst mem ops", 32'(mop_q.size()), 32'd0);
        mop_q.delete();
        @(posedge clk);
        #1;
        push_mop(0, 32'h10, 0); issue(0, 3'd2, 32'h10, 0, 32'h8899AABB, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
